// File: rtl/im_pkg.sv
// Shared constants, FSM state type and word assembly for the instruction-memory loader.
package im_pkg;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Big-endian: the byte at the lowest address becomes the most significant byte.
  function automatic logic [31:0] be_word(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/im_byte_ram.sv
// Byte storage: one synchronous write port, four combinational read taps with modulo indexing.
module im_byte_ram
  import im_pkg::*;
#(
  parameter int unsigned DEPTH = im_pkg::DEPTH,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Index arithmetic is IDX_W wide, so a word straddling the top wraps to address 0.
  logic [IDX_W-1:0] idx1, idx2, idx3;

  always_comb begin
    idx1  = raddr + IDX_W'(1);
    idx2  = raddr + IDX_W'(2);
    idx3  = raddr + IDX_W'(3);
    rdata = be_word(mem[raddr], mem[idx1], mem[idx2], mem[idx3]);
  end

endmodule

// File: rtl/im_loader.sv
// Run-time loadable instruction memory: streams bytes in over valid/ready, serves big-endian word fetches.
module im_loader
  import im_pkg::*;
#(
  parameter int unsigned DEPTH  = im_pkg::DEPTH,
  parameter int unsigned ADDR_W = im_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] byte_cnt,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] remaining;
  logic              we;
  logic [ADDR_W:0]   end_addr;
  logic              reject;
  logic              unused_hi;

  // Bound check is done one bit wider so base+count cannot silently overflow.
  always_comb begin
    end_addr = {1'b0, base_addr} + {1'b0, byte_cnt};
    reject   = ({1'b0, base_addr} >= DEPTH_X) || (end_addr > DEPTH_X);
    we       = in_valid && in_ready;
  end

  assign unused_hi = ^{raddr[ADDR_W-1:IDX_W], ptr[ADDR_W-1:IDX_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load_start) begin
            if (reject) begin
              err <= 1'b1;
            end else begin
              err <= 1'b0;
              if (byte_cnt == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                ptr       <= base_addr;
                remaining <= byte_cnt;
                state     <= LOAD;
                in_ready  <= 1'b1;
                busy      <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          if (we) begin
            ptr       <= ptr + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
            if (remaining == ADDR_W'(1)) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  im_byte_ram #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(ptr[IDX_W-1:0]),
    .wdata(in_data),
    .raddr(raddr[IDX_W-1:0]),
    .rdata(rdata)
  );

endmodule

// File: doc/im_loader.md
# im_loader

Writable instruction memory that fills its byte array from a byte stream and serves big-endian 32-bit instruction fetches. It is the writer side of the instruction-fetch byte store: a host or testbench streams program bytes in over a valid/ready handshake, then the CPU fetch stage reads words through the same 12-bit byte-address port the fetch path already uses. It replaces a preloaded ROM wherever a program must be loaded at run time.

## Interface
- DEPTH, 1024, storage size in bytes (power of two)
- ADDR_W, 12, byte-address width on all address ports
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  synchronous, active-high reset
- load_start  input  1  one-cycle request to begin a load (sampled in IDLE only)
- base_addr  input  ADDR_W  first byte address to write (sampled with load_start)
- byte_cnt  input  ADDR_W  number of bytes to write (sampled with load_start)
- in_valid  input  1  in_data holds a byte
- in_data  input  8  program byte
- in_ready  output  1  block accepts a byte this cycle
- busy  output  1  load in progress
- done  output  1  one-cycle pulse: load finished
- err  output  1  sticky: load request rejected
- raddr  input  ADDR_W  fetch byte address
- rdata  output  32  {mem[raddr], mem[raddr+1], mem[raddr+2], mem[raddr+3]}

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: in_ready=0, busy=0. On load_start:
  - base_addr >= DEPTH or base_addr+byte_cnt (ADDR_W+1 bits) > DEPTH: err<=1, stay IDLE, no writes.
  - byte_cnt==0: go DONE, no writes.
  - else: ptr<=base_addr, remaining<=byte_cnt, go LOAD.
- LOAD: in_ready=1, busy=1. Each in_valid&&in_ready cycle: mem[ptr]<=in_data, ptr<=ptr+1, remaining<=remaining-1. The handshake with remaining==1 writes the last byte and goes to DONE. in_valid low: hold and write nothing.
- DONE: done=1, busy=0, in_ready=0; next cycle IDLE.
- load_start outside IDLE is ignored.
- err clears only on rst or on an accepted (non-rejected) load_start.
- Read port is combinational and always live. Byte index = (raddr+k) mod DEPTH using the low log2(DEPTH) bits, so a word read at DEPTH-2 wraps to bytes 0..1. No alignment check; raddr is used as given, with no base-offset subtraction.
- Byte order is big-endian: mem[raddr] lands in rdata[31:24].

## Timing
- Reset values: state IDLE, in_ready=0, busy=0, done=0, err=0, ptr=0, remaining=0. Memory contents are not cleared.
- rst mid-LOAD aborts the load. Bytes already written stay; bytes not yet written keep their old values. No done pulse.
- A write accepted at edge N is visible on rdata from edge N (same cycle after the edge). Reading the address being written in the handshake cycle returns the old byte.
- load_start at edge N → LOAD from N+1, so in_ready is first high in cycle N+1.
- Throughput: one byte per cycle. A load of C bytes with in_valid held high: done is high in cycle N+C+1.
- Zero-length load: done is high in cycle N+1.
- Rejected load: err is high from cycle N+1.

## Structure
- Shared package im_pkg holds: DEPTH, ADDR_W, IDX_W=log2(DEPTH), the state enum (IDLE/LOAD/DONE), and the big-endian word-assembly function.
- Sub-module im_byte_ram holds the storage: DEPTH×8 array, one synchronous write port (we, waddr, wdata) and four combinational read taps with modulo indexing.
- im_loader holds the FSM, the ptr/remaining counters, the bound check and the handshake.

## Test plan
- Basic load: base 0, cnt 8, bytes 0x20,0x08,0x00,0x05,0x3c,0x01,0x00,0x10 with in_valid held high → done 9 cycles after start; raddr 0 → 0x20080005, raddr 4 → 0x3c010010.
- Backpressure: cnt 4 at base 0x100, in_valid toggling 1,0,0,1,1,0,1 → exactly 4 writes, only on valid cycles; raddr 0x100 returns the bytes in order; busy is high throughout.
- Bounds: base 0x3FE, cnt 3 → err=1, no writes, state IDLE. Next load base 0x3FC, cnt 4 → accepted, err clears, done pulses.
- Wrap read: after loading 0xAA,0xBB at 0x3FE..0x3FF and 0xCC,0xDD at 0x000..0x001, raddr 0x3FE → 0xAABBCCDD.
- Reset mid-load: cnt 8, rst asserted after 3 bytes → busy=0, in_ready=0, done never pulses, the first 3 bytes are present and the rest are unchanged.
- Zero-length and ignored start: cnt 0 → done the next cycle, no writes. load_start during LOAD → ignored; the current load completes with its original count.
